// File: rtl/bank_pkg.sv
// rtl/bank_pkg.sv - shared state encoding, parameter defaults and clog2 helper for the door interlock
package bank_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OPEN  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int DEF_N_DOORS     = 2;
  localparam int DEF_PERIOD_CYC  = 240000;
  localparam int DEF_POS_OPEN    = 27000;
  localparam int DEF_POS_LOCK    = 77000;
  localparam int DEF_STEP        = 5000;
  localparam int DEF_DEB_CYC     = 120000;
  localparam int DEF_HOLD_FRAMES = 25;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchroniser plus stability-time debounce for one door sensor
module switch_debounce
  import bank_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = clog2(DEB_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive cycles the synchronised input disagrees with deb
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/interlock_servo_ctrl.sv
// rtl/interlock_servo_ctrl.sv - single-owner door interlock driving slew-limited lock servos
module interlock_servo_ctrl
  import bank_pkg::*;
#(
  parameter int N_DOORS     = DEF_N_DOORS,
  parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
  parameter int POS_OPEN    = DEF_POS_OPEN,
  parameter int POS_LOCK    = DEF_POS_LOCK,
  parameter int STEP        = DEF_STEP,
  parameter int DEB_CYC     = DEF_DEB_CYC,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_DOORS-1:0]          switches,
  output logic [N_DOORS-1:0]          servo,
  output logic                        alarm,
  output logic [clog2(N_DOORS)-1:0]   owner,
  output logic [1:0]                  state
);

  localparam int OW = clog2(N_DOORS);
  localparam int PW = clog2(PERIOD_CYC + 1);
  localparam int HW = clog2(HOLD_FRAMES + 1);

  localparam logic [PW-1:0] OPEN_W = PW'(POS_OPEN);
  localparam logic [PW-1:0] LOCK_W = PW'(POS_LOCK);
  localparam logic [PW-1:0] STEP_W = PW'(STEP);
  localparam logic [PW-1:0] LAST_W = PW'(PERIOD_CYC - 1);

  if (POS_OPEN > PERIOD_CYC || POS_LOCK > PERIOD_CYC) begin : g_bad_pos
    $error("POS_OPEN and POS_LOCK must not exceed PERIOD_CYC");
  end

  logic [N_DOORS-1:0] deb;
  logic [PW-1:0]      cnt;
  logic               frame_end;
  logic [PW-1:0]      pos [N_DOORS];
  logic [PW-1:0]      tgt [N_DOORS];
  logic [HW-1:0]      hold_cnt;
  logic [HW-1:0]      hold_n;
  logic [1:0]         state_n;
  logic [OW-1:0]      owner_n;
  logic [OW-1:0]      first_idx;
  logic [N_DOORS-1:0] owner_mask;
  int                 n_open;

  for (genvar g = 0; g < N_DOORS; g++) begin : g_deb
    switch_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (switches[g]),
      .deb   (deb[g])
    );
  end

  assign frame_end = (cnt == LAST_W);
  assign alarm     = (state == ST_FAULT);

  always_comb begin
    n_open     = 0;
    first_idx  = '0;
    owner_mask = '0;
    for (int i = 0; i < N_DOORS; i++) begin
      n_open = n_open + int'(deb[i]);
      if (deb[i]) first_idx = OW'(i);
    end
    owner_mask[owner] = 1'b1;

    state_n = state;
    owner_n = owner;
    hold_n  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (n_open == 1) begin
          state_n = ST_OPEN;
          owner_n = first_idx;
        end else if (n_open > 1) begin
          state_n = ST_FAULT;
        end
      end
      ST_OPEN: begin
        if ((deb & ~owner_mask) != '0) begin
          state_n = ST_FAULT;
        end else if (deb == '0) begin
          state_n = ST_HOLD;
          hold_n  = '0;
        end
      end
      ST_HOLD: begin
        if (deb != '0) begin
          state_n = ST_FAULT;
          hold_n  = '0;
        end else if (frame_end) begin
          if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
            state_n = ST_IDLE;
            hold_n  = '0;
          end else begin
            hold_n = hold_cnt + HW'(1);
          end
        end
      end
      default: begin
        if (deb == '0) begin
          state_n = ST_HOLD;
          hold_n  = '0;
        end
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_DOORS; i++) begin
      tgt[i] = (state == ST_IDLE || (state == ST_OPEN && owner == OW'(i))) ? OPEN_W : LOCK_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      hold_cnt <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      hold_cnt <= hold_n;
      cnt      <= frame_end ? '0 : cnt + PW'(1);
    end
  end

  // Positions only move on the frame boundary so a pulse is never cut short mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      servo <= '0;
      for (int i = 0; i < N_DOORS; i++) pos[i] <= OPEN_W;
    end else begin
      for (int i = 0; i < N_DOORS; i++) begin
        servo[i] <= (cnt < pos[i]);
        if (frame_end) begin
          if (pos[i] < tgt[i]) begin
            pos[i] <= (tgt[i] - pos[i] > STEP_W) ? pos[i] + STEP_W : tgt[i];
          end else if (pos[i] > tgt[i]) begin
            pos[i] <= (pos[i] - tgt[i] > STEP_W) ? pos[i] - STEP_W : tgt[i];
          end
        end
      end
    end
  end

endmodule
